frame_buf_scan: RTL
===================

# frame_buf_scan

Parametrised frame store with a write port for camera pixels and a scan engine that streams the stored frame back out, either one pixel per beat or one multi-pixel block per beat, under a valid/ready handshake. It sits between the camera capture path and downstream image-processing consumers. It generalises the fixed 320x240, 8-bit, 16-pixel-block memory to arbitrary resolution and block size. It adds a start/length scan engine, wrap-around, backpressure and an optional continuous-loop mode.

## Interface
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame
- PIX_W, 8, bits per pixel
- BLK_PIX, 16, pixels per block; must be a power of two and must divide H_RES*V_RES
- Derived localparams:
  - PIX_CNT = H_RES*V_RES (76800)
  - BLK_CNT = PIX_CNT/BLK_PIX (4800)
  - PA_W = clog2(PIX_CNT) (17)
  - BA_W = clog2(BLK_CNT) (13)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- wr_en  in  1  pixel write strobe
- wr_addr  in  PA_W  pixel write address
- wr_data  in  PIX_W  pixel write data
- scan_start  in  1  one-cycle request to begin a scan
- scan_mode  in  1  0 = pixel beats, 1 = block beats; sampled on the accepted start
- scan_base  in  PA_W  first address of the scan, in units of the selected mode; sampled on start
- scan_len  in  PA_W  number of beats; 0 means one full frame (PIX_CNT or BLK_CNT); sampled on start
- scan_cont  in  1  loop the scan until scan_stop; sampled on start
- scan_stop  in  1  abort the scan
- out_ready  in  1  downstream accepts the beat
- out_valid  out  1  out_data, out_addr and out_last are valid
- out_data  out  BLK_PIX*PIX_W  block beat: pixel 0 of the block in the LSBs; pixel beat: pixel in [PIX_W-1:0], upper bits 0
- out_addr  out  PA_W  address of the current beat, in units of the selected mode
- out_last  out  1  final beat of the scan pass
- busy  out  1  scan in progress, including pipeline drain
- start_err  out  1  one-cycle pulse when scan_base is out of range

## Operation
- Storage is BLK_PIX lanes, each BLK_CNT deep.
  - A pixel at address a lives in lane a % BLK_PIX, row a / BLK_PIX.
  - Reads are synchronous, one cycle.
- Writes:
  - A write occurs when wr_en=1 and wr_addr < PIX_CNT. Out-of-range writes are dropped silently.
  - Writes are independent of scanning.
  - Same-cycle read and write of one location returns the old data (read-first).
- FSM states are IDLE, RUN and DRAIN.
  - IDLE -> RUN on scan_start. The mode, base, length and cont inputs are latched, and the beat counter is loaded with the length.
  - If scan_base >= limit (PIX_CNT in pixel mode, BLK_CNT in block mode), start_err pulses and the scan begins at address 0.
  - scan_start is ignored while busy=1.
  - RUN issues one read per advance, where advance = !out_valid || out_ready.
  - On the last issued read, RUN -> DRAIN. With cont latched, the engine instead reloads the base and length and stays in RUN.
  - DRAIN -> IDLE once the final beat is accepted.
- Addressing:
  - The read address increments by 1 per issued read.
  - It wraps from limit-1 to 0, with no gap.
  - In pixel mode, the pixel is selected from the block row by lane index through a registered mux.
- out_last is 1 on the beat whose remaining count is 1. In continuous mode this marks every pass end.
- scan_stop in RUN or DRAIN:
  - No further reads are issued.
  - out_valid drops the next cycle, and any in-flight beat is discarded.
  - The FSM returns to IDLE on that next cycle.
  - scan_stop takes priority over scan_start in the same cycle.
- Reset:
  - FSM goes to IDLE.
  - out_valid, out_last, busy and start_err are 0.
  - out_data and out_addr are 0.
  - Memory contents are not cleared.
  - Reset mid-scan aborts the scan immediately.

## Timing
- scan_start accepted at edge N: busy=1 after N, first read issued on edge N+1, out_valid=1 after N+2.
- Start-to-first-beat latency is 2 cycles.
- Throughput is 1 beat/cycle while out_ready=1.
- With out_ready=0, out_data, out_addr and out_last are held stable, and no read is issued.
- There is no beat loss or duplication across stalls of any length.
- busy falls on the edge after the final beat is accepted.
- A write at edge W is visible to a read issued at edge W+1 or later.

## Configuration
- FBS_CONT_EN defined: continuous-loop mode exists as described under Operation.
- FBS_CONT_EN undefined: scan_cont is ignored (treated as 0), and every scan is single-pass.

## Test plan
- Write pixel i = i[7:0] for all 76800 addresses. Block scan, base 0, len 0, out_ready=1 -> 4800 beats, beat k = {16 bytes (16k+15..16k)[7:0]}; out_last only on k=4799; busy low 1 cycle after.
- Pixel scan, base 76798, len 4 -> out_addr 76798, 76799, 0, 1 with data 0xFE, 0xFF, 0x00, 0x01; out_last on 4th beat.
- Block scan, base 765, len 8, out_ready toggling 1/0 every cycle -> beats addresses 765..772 in order, data stable while stalled, exactly 8 handshakes.
- Block scan, base 4800 -> start_err pulses once, first out_addr=0.
- With FBS_CONT_EN: pixel scan, base 10, len 3, cont=1 -> addresses 10, 11, 12, 10, 11, 12...; out_last on every 12. scan_stop -> out_valid=0 next cycle, busy=0 next cycle. Without FBS_CONT_EN: same stimulus -> exactly 3 beats.
- Reset asserted mid block scan at beat 100 -> all outputs 0 next cycle. A fresh scan_start afterwards starts cleanly at its base, and memory data is intact.

Source files
------------

// File: rtl/frame_buf_scan.sv
// frame_buf_scan
// Frame store split into BLK_PIX pixel lanes with an independent pixel write
// port and a scan engine that streams pixel or block beats under valid/ready.
// Define FBS_CONT_EN to build continuous-loop scanning (scan_cont); without it
// scan_cont is ignored and every scan is a single pass.
module frame_buf_scan #(
   parameter int H_RES   = 320,
   parameter int V_RES   = 240,
   parameter int PIX_W   = 8,
   parameter int BLK_PIX = 16,
   localparam int PIX_CNT = H_RES * V_RES,
   localparam int BLK_CNT = PIX_CNT / BLK_PIX,
   localparam int PA_W    = $clog2(PIX_CNT),
   localparam int BA_W    = $clog2(BLK_CNT)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [PA_W-1:0]          wr_addr,
   input  logic [PIX_W-1:0]         wr_data,
   input  logic                     scan_start,
   input  logic                     scan_mode,
   input  logic [PA_W-1:0]          scan_base,
   input  logic [PA_W-1:0]          scan_len,
   input  logic                     scan_cont,
   input  logic                     scan_stop,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [BLK_PIX*PIX_W-1:0] out_data,
   output logic [PA_W-1:0]          out_addr,
   output logic                     out_last,
   output logic                     busy,
   output logic                     start_err
);
   localparam int LN_W = (BLK_PIX > 1) ? $clog2(BLK_PIX) : 1;
   localparam int CW   = PA_W + 1;
   localparam int DW   = BLK_PIX * PIX_W;
   localparam logic [CW-1:0] PIX_LIM = CW'(PIX_CNT);
   localparam logic [CW-1:0] BLK_LIM = CW'(BLK_CNT);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state_q, state_d;

   logic [PIX_W-1:0] lane_mem [BLK_PIX][BLK_CNT];
   logic [PIX_W-1:0] rd_lane  [BLK_PIX];
   logic [DW-1:0]    rd_word, pix_word;

   logic             wr_hit;
   logic [LN_W-1:0]  wr_lane;
   logic [BA_W-1:0]  wr_row, rd_row;

   logic             cont_in, mode_q, cont_q;
   logic [PA_W-1:0]  base_q, rd_addr, addr_inc, base_in;
   logic [CW-1:0]    len_q, beats_left, len_in, lim_in, lim_q;
   logic             base_bad;

   logic             s1_valid, s1_last;
   logic [PA_W-1:0]  s1_addr;
   logic [LN_W-1:0]  s1_lane;

   logic             advance, start_ok, issue, flush;

`ifdef FBS_CONT_EN
   assign cont_in = scan_cont;
`else
   logic unused_cont;
   assign cont_in     = 1'b0;
   assign unused_cont = scan_cont;
`endif

   assign wr_hit  = wr_en && ({1'b0, wr_addr} < PIX_LIM);
   assign wr_lane = LN_W'(wr_addr % BLK_PIX);
   assign wr_row  = BA_W'(wr_addr / BLK_PIX);
   assign busy    = (state_q != IDLE);
   assign advance = !out_valid || out_ready;
   assign flush   = scan_stop && (state_q != IDLE);

   // Lane memories: pixel write port and read-first block-row read
   always_ff @(posedge clk) begin
      if (wr_hit) lane_mem[wr_lane][wr_row] <= wr_data;
      if (issue) begin
         for (int unsigned l = 0; l < BLK_PIX; l++) rd_lane[l] <= lane_mem[l][rd_row];
      end
   end

   // Start decode, address stepping and pixel/block word assembly
   always_comb begin
      lim_in   = scan_mode ? BLK_LIM : PIX_LIM;
      base_bad = ({1'b0, scan_base} >= lim_in);
      base_in  = base_bad ? '0 : scan_base;
      len_in   = (scan_len == '0) ? lim_in : {1'b0, scan_len};
      lim_q    = mode_q ? BLK_LIM : PIX_LIM;
      addr_inc = ({1'b0, rd_addr} == lim_q - CW'(1)) ? '0 : rd_addr + PA_W'(1);
      rd_row   = mode_q ? BA_W'(rd_addr) : BA_W'(rd_addr / BLK_PIX);
      rd_word  = '0;
      pix_word = '0;
      for (int unsigned l = 0; l < BLK_PIX; l++) rd_word[l*PIX_W +: PIX_W] = rd_lane[l];
      pix_word[PIX_W-1:0] = rd_lane[s1_lane];
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state and read-issue decision
   always_comb begin
      state_d  = state_q;
      start_ok = 1'b0;
      issue    = 1'b0;
      case (state_q)
         IDLE: begin
            if (scan_start && !scan_stop) begin
               start_ok = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (scan_stop) state_d = IDLE;
            else if (advance) begin
               issue = 1'b1;
               if (beats_left == CW'(1) && !cont_q) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (scan_stop)                  state_d = IDLE;
            else if (!s1_valid && advance) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Scan registers and the two-stage read/output pipeline; the whole
   // pipeline moves only on advance so stalls neither lose nor repeat beats
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q     <= 1'b0;
         cont_q     <= 1'b0;
         base_q     <= '0;
         len_q      <= '0;
         rd_addr    <= '0;
         beats_left <= '0;
         s1_valid   <= 1'b0;
         s1_last    <= 1'b0;
         s1_addr    <= '0;
         s1_lane    <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_addr   <= '0;
         out_last   <= 1'b0;
         start_err  <= 1'b0;
      end else begin
         start_err <= start_ok && base_bad;
         if (start_ok) begin
            mode_q     <= scan_mode;
            cont_q     <= cont_in;
            base_q     <= base_in;
            len_q      <= len_in;
            rd_addr    <= base_in;
            beats_left <= len_in;
         end else if (issue) begin
            // reload at pass end; harmless for single pass since DRAIN follows
            if (beats_left == CW'(1)) begin
               rd_addr    <= base_q;
               beats_left <= len_q;
            end else begin
               rd_addr    <= addr_inc;
               beats_left <= beats_left - CW'(1);
            end
         end
         if (flush) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else if (advance) begin
            s1_valid <= issue;
            if (issue) begin
               s1_addr <= rd_addr;
               s1_last <= (beats_left == CW'(1));
               s1_lane <= LN_W'(rd_addr % BLK_PIX);
            end
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            if (s1_valid) begin
               out_addr <= s1_addr;
               out_data <= mode_q ? rd_word : pix_word;
            end
         end
      end
   end
endmodule
